// File: rtl/xm_wb_pkg.sv
`default_nettype none
// ============================================================================
// Module  : xm_wb_pkg
// Purpose : Shared types and widths for the two-master Wishbone arbiter.
//           - arbiter state encoding
//           - default bus widths for the 16-bit word memory
// Ports   : none (package)
// Revision: 1.0  initial release
// ============================================================================
package xm_wb_pkg;

  typedef enum logic [1:0] {
    ARB_IDLE = 2'd0,
    ARB_GNT0 = 2'd1,
    ARB_GNT1 = 2'd2
  } arb_state_t;

  localparam int WB_ADR_W = 15;
  localparam int WB_DAT_W = 16;
  localparam int WB_SEL_W = 2;

endpackage
`default_nettype wire

// File: rtl/wb_watchdog.sv
`default_nettype none
// ============================================================================
// Module  : wb_watchdog
// Purpose : Counts consecutive stalled strobe cycles and flags the cycle in
//           which a strobe has waited TIMEOUT cycles without an ack.
//           TIMEOUT = 0 disables the watchdog (expire_o never asserts).
// Ports   : clk_i     clock
//           rst_n_i   asynchronous active-low reset
//           run_i     strobe active with no ack this cycle
//           clr_i     restart the count at the next edge
//           expire_o  current cycle is the last one allowed without ack
// Revision: 1.0  initial release
// ============================================================================
module wb_watchdog
  import xm_wb_pkg::*;
#(
  parameter int TIMEOUT = 16
) (
  input  logic clk_i,
  input  logic rst_n_i,
  input  logic run_i,
  input  logic clr_i,
  output logic expire_o
);

  // A zero-width counter is illegal, so the disabled case keeps one bit.
  localparam int CNT_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(TIMEOUT);
  localparam logic [CNT_W-1:0] CNT_LAST = (TIMEOUT > 0) ? CNT_W'(TIMEOUT - 1) : '0;

  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (run_i && (cnt_q != CNT_MAX)) begin
      // Saturate rather than wrap so a stuck count can never re-arm.
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign expire_o = (TIMEOUT != 0) && run_i && (cnt_q == CNT_LAST);

endmodule
`default_nettype wire

// File: rtl/wb_arbiter_2m.sv
`default_nettype none
// ============================================================================
// Module  : wb_arbiter_2m
// Purpose : Two-master / one-slave Wishbone classic arbiter. Round-robin
//           grant, bus lock while the owner holds cyc, per-strobe ack
//           watchdog with forced release.
// Ports   : clk_i, rst_n_i                clock, async active-low reset
//           mN_cyc/stb/we/sel/adr/dat_i   master N request (N = 0,1)
//           mN_ack_o, mN_err_o, mN_dat_o  responses routed to master N
//           s_cyc/stb/we/sel/adr/dat_o    owner's request to the slave
//           s_ack_i, s_dat_i              slave response
//           gnt_o                         one-hot owner, 00 = idle
// Revision: 1.0  initial release
// ============================================================================
module wb_arbiter_2m
  import xm_wb_pkg::*;
#(
  parameter int ADR_W   = WB_ADR_W,
  parameter int DAT_W   = WB_DAT_W,
  parameter int SEL_W   = WB_SEL_W,
  parameter int TIMEOUT = 16
) (
  input  logic             clk_i,
  input  logic             rst_n_i,
  input  logic             m0_cyc_i,
  input  logic             m0_stb_i,
  input  logic             m0_we_i,
  input  logic [SEL_W-1:0] m0_sel_i,
  input  logic [ADR_W-1:0] m0_adr_i,
  input  logic [DAT_W-1:0] m0_dat_i,
  output logic             m0_ack_o,
  output logic             m0_err_o,
  output logic [DAT_W-1:0] m0_dat_o,
  input  logic             m1_cyc_i,
  input  logic             m1_stb_i,
  input  logic             m1_we_i,
  input  logic [SEL_W-1:0] m1_sel_i,
  input  logic [ADR_W-1:0] m1_adr_i,
  input  logic [DAT_W-1:0] m1_dat_i,
  output logic             m1_ack_o,
  output logic             m1_err_o,
  output logic [DAT_W-1:0] m1_dat_o,
  output logic             s_cyc_o,
  output logic             s_stb_o,
  output logic             s_we_o,
  output logic [SEL_W-1:0] s_sel_o,
  output logic [ADR_W-1:0] s_adr_o,
  output logic [DAT_W-1:0] s_dat_o,
  input  logic             s_ack_i,
  input  logic [DAT_W-1:0] s_dat_i,
  output logic [1:0]       gnt_o
);

  localparam logic [1:0] ST_IDLE = 2'(ARB_IDLE);
  localparam logic [1:0] ST_GNT0 = 2'(ARB_GNT0);
  localparam logic [1:0] ST_GNT1 = 2'(ARB_GNT1);

  logic [1:0] state_q, state_d;
  logic       last_q, last_d;   // previous owner, 1 after reset so M0 wins first tie
  logic       own0, own1;
  logic       wdt_run, wdt_clr, wdt_expire;

  assign own0 = (state_q == ST_GNT0);
  assign own1 = (state_q == ST_GNT1);

  // Slave side: pure combinational mux of the owner, all zero when idle.
  always_comb begin
    s_cyc_o = 1'b0;
    s_stb_o = 1'b0;
    s_we_o  = 1'b0;
    s_sel_o = '0;
    s_adr_o = '0;
    s_dat_o = '0;
    if (own0) begin
      s_cyc_o = m0_cyc_i;
      s_stb_o = m0_stb_i;
      s_we_o  = m0_we_i;
      s_sel_o = m0_sel_i;
      s_adr_o = m0_adr_i;
      s_dat_o = m0_dat_i;
    end else if (own1) begin
      s_cyc_o = m1_cyc_i;
      s_stb_o = m1_stb_i;
      s_we_o  = m1_we_i;
      s_sel_o = m1_sel_i;
      s_adr_o = m1_adr_i;
      s_dat_o = m1_dat_i;
    end
  end

  // An ack in the final allowed cycle stops the watchdog from running, so
  // ack always takes precedence over expiry.
  assign wdt_run = s_stb_o & ~s_ack_i;
  assign wdt_clr = ~wdt_run | (state_d != state_q);

  wb_watchdog #(
    .TIMEOUT (TIMEOUT)
  ) u_wdt (
    .clk_i    (clk_i),
    .rst_n_i  (rst_n_i),
    .run_i    (wdt_run),
    .clr_i    (wdt_clr),
    .expire_o (wdt_expire)
  );

  always_comb begin
    state_d = state_q;
    last_d  = last_q;
    case (state_q)
      ST_IDLE: begin
        if (m0_cyc_i && m1_cyc_i) begin
          state_d = last_q ? ST_GNT0 : ST_GNT1;
        end else if (m0_cyc_i) begin
          state_d = ST_GNT0;
        end else if (m1_cyc_i) begin
          state_d = ST_GNT1;
        end
      end
      ST_GNT0: begin
        // Release on cyc drop or watchdog expiry; hand straight over if M1 waits.
        if (!m0_cyc_i || wdt_expire) begin
          last_d  = 1'b0;
          state_d = m1_cyc_i ? ST_GNT1 : ST_IDLE;
        end
      end
      ST_GNT1: begin
        if (!m1_cyc_i || wdt_expire) begin
          last_d  = 1'b1;
          state_d = m0_cyc_i ? ST_GNT0 : ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q <= ST_IDLE;
      last_q  <= 1'b1;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
    end
  end

  // Responses only reach the current owner; a late ack while idle is dropped.
  assign m0_ack_o = s_ack_i & own0 & m0_stb_i;
  assign m1_ack_o = s_ack_i & own1 & m1_stb_i;
  assign m0_err_o = wdt_expire & own0;
  assign m1_err_o = wdt_expire & own1;
  assign m0_dat_o = own0 ? s_dat_i : '0;
  assign m1_dat_o = own1 ? s_dat_i : '0;
  assign gnt_o    = {own1, own0};

endmodule
`default_nettype wire

// File: tb/tb_wb_arbiter_2m.sv
`default_nettype none
// ============================================================================
// Module  : tb_wb_arbiter_2m
// Purpose : Self-checking bench for wb_arbiter_2m. Expected read data is
//           queued when a strobe is issued and popped when the owning master
//           sees its ack.
// Revision: 1.0  initial release
// ============================================================================
module tb_wb_arbiter_2m;

  localparam int ADR_W = 15;
  localparam int DAT_W = 16;
  localparam int SEL_W = 2;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             m0_cyc = 0, m0_stb = 0, m0_we = 0;
  logic [SEL_W-1:0] m0_sel = '0;
  logic [ADR_W-1:0] m0_adr = '0;
  logic [DAT_W-1:0] m0_wdat = '0;
  logic             m0_ack, m0_err;
  logic [DAT_W-1:0] m0_rdat;
  logic             m1_cyc = 0, m1_stb = 0, m1_we = 0;
  logic [SEL_W-1:0] m1_sel = '0;
  logic [ADR_W-1:0] m1_adr = '0;
  logic [DAT_W-1:0] m1_wdat = '0;
  logic             m1_ack, m1_err;
  logic [DAT_W-1:0] m1_rdat;
  logic             s_cyc, s_stb, s_we;
  logic [SEL_W-1:0] s_sel;
  logic [ADR_W-1:0] s_adr;
  logic [DAT_W-1:0] s_wdat;
  logic             s_ack = 0;
  logic [DAT_W-1:0] s_rdat = '0;
  logic [1:0]       gnt;

  int n_cmp = 0;
  int n_bad = 0;
  logic [DAT_W-1:0] exp_q[$];
  logic [DAT_W-1:0] exp_v;

  always #5 clk = ~clk;

  wb_arbiter_2m #(
    .ADR_W(ADR_W), .DAT_W(DAT_W), .SEL_W(SEL_W), .TIMEOUT(16)
  ) dut (
    .clk_i(clk), .rst_n_i(rst_n),
    .m0_cyc_i(m0_cyc), .m0_stb_i(m0_stb), .m0_we_i(m0_we), .m0_sel_i(m0_sel),
    .m0_adr_i(m0_adr), .m0_dat_i(m0_wdat),
    .m0_ack_o(m0_ack), .m0_err_o(m0_err), .m0_dat_o(m0_rdat),
    .m1_cyc_i(m1_cyc), .m1_stb_i(m1_stb), .m1_we_i(m1_we), .m1_sel_i(m1_sel),
    .m1_adr_i(m1_adr), .m1_dat_i(m1_wdat),
    .m1_ack_o(m1_ack), .m1_err_o(m1_err), .m1_dat_o(m1_rdat),
    .s_cyc_o(s_cyc), .s_stb_o(s_stb), .s_we_o(s_we), .s_sel_o(s_sel),
    .s_adr_o(s_adr), .s_dat_o(s_wdat),
    .s_ack_i(s_ack), .s_dat_i(s_rdat),
    .gnt_o(gnt)
  );

  // Drive point: just after the rising edge. Check point: falling edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic mid();
    @(negedge clk);
  endtask

  task automatic idle_all();
    m0_cyc = 0; m0_stb = 0; m0_we = 0;
    m1_cyc = 0; m1_stb = 0; m1_we = 0;
    s_ack = 0; s_rdat = '0;
  endtask

  task automatic do_reset();
    idle_all();
    rst_n = 1'b0;
    tick(); tick();
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_reset();
    do_reset();
    mid();
    n_cmp++; if (gnt !== 2'b00 || s_cyc !== 1'b0) begin
      n_bad++; $display("FAIL reset_idle: gnt=%b s_cyc=%b, want 00/0", gnt, s_cyc);
    end
    // M1 write in progress, then async reset asserted mid-transfer.
    tick();
    m1_cyc = 1; m1_stb = 1; m1_we = 1; m1_adr = 15'h0123; m1_wdat = 16'h5A5A; m1_sel = 2'b11;
    tick();
    mid();
    n_cmp++; if (gnt !== 2'b10 || s_cyc !== 1'b1 || s_we !== 1'b1 || s_adr !== 15'h0123 || s_wdat !== 16'h5A5A) begin
      n_bad++; $display("FAIL gnt1_write: gnt=%b cyc=%b we=%b adr=%h dat=%h, want 10/1/1/0123/5a5a",
                        gnt, s_cyc, s_we, s_adr, s_wdat);
    end
    s_ack = 1;
    #1 rst_n = 1'b0;
    #1;
    n_cmp++; if (s_cyc !== 0 || s_stb !== 0 || gnt !== 2'b00 || m0_ack !== 0 || m1_ack !== 0 || m0_err !== 0 || m1_err !== 0) begin
      n_bad++; $display("FAIL async_reset: cyc=%b stb=%b gnt=%b acks=%b%b errs=%b%b, want all 0",
                        s_cyc, s_stb, gnt, m0_ack, m1_ack, m0_err, m1_err);
    end
    idle_all();
    tick();
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_single();
    m0_cyc = 1; m0_stb = 1; m0_we = 0; m0_adr = 15'h0010; m0_sel = 2'b11;
    exp_q.push_back(16'hBEEF);
    mid();
    n_cmp++; if (gnt !== 2'b00 || s_stb !== 1'b0) begin
      n_bad++; $display("FAIL grant_latency: gnt=%b s_stb=%b, want 00/0", gnt, s_stb);
    end
    tick();
    mid();
    n_cmp++; if (gnt !== 2'b01 || s_adr !== 15'h0010 || s_stb !== 1'b1 || m0_ack !== 1'b0) begin
      n_bad++; $display("FAIL m0_granted: gnt=%b adr=%h stb=%b ack=%b, want 01/0010/1/0", gnt, s_adr, s_stb, m0_ack);
    end
    tick();
    tick();
    s_ack = 1; s_rdat = 16'hBEEF;
    mid();
    n_cmp++; if (m0_ack !== 1'b1 || m1_ack !== 1'b0) begin
      n_bad++; $display("FAIL m0_read_ack: m0_ack=%b m1_ack=%b, want 1/0", m0_ack, m1_ack);
    end
    if (m0_ack === 1'b1) begin
      exp_v = (exp_q.size() > 0) ? exp_q.pop_front() : 16'hxxxx;
      n_cmp++; if (m0_rdat !== exp_v) begin
        n_bad++; $display("FAIL m0_read_data: got %h, want %h", m0_rdat, exp_v);
      end
    end
    n_cmp++; if (m1_rdat !== 16'h0000) begin
      n_bad++; $display("FAIL non_owner_dat: m1_dat=%h, want 0000", m1_rdat);
    end
    tick();
    idle_all();
    tick();
    mid();
    n_cmp++; if (gnt !== 2'b00) begin
      n_bad++; $display("FAIL release_idle: gnt=%b, want 00", gnt);
    end
  endtask

  task automatic test_tie();
    do_reset();
    m0_cyc = 1; m1_cyc = 1;
    tick();
    mid();
    n_cmp++; if (gnt !== 2'b01) begin
      n_bad++; $display("FAIL tie_first: gnt=%b, want 01", gnt);
    end
    tick();
    m0_cyc = 0;
    tick();
    mid();
    n_cmp++; if (gnt !== 2'b10) begin
      n_bad++; $display("FAIL handover: gnt=%b, want 10", gnt);
    end
    tick();
    m1_cyc = 0;
    tick();
    m0_cyc = 1; m1_cyc = 1;
    mid();
    n_cmp++; if (gnt !== 2'b00) begin
      n_bad++; $display("FAIL tie_gap_idle: gnt=%b, want 00", gnt);
    end
    tick();
    mid();
    n_cmp++; if (gnt !== 2'b01) begin
      n_bad++; $display("FAIL tie_alternate: gnt=%b, want 01", gnt);
    end
    tick();
    idle_all();
    tick();
  endtask

  // Last owner is M0 here, so a tie goes to M1, which then locks 3 strobes.
  task automatic test_lock();
    int done;
    done = 0;
    m0_cyc = 1; m0_stb = 1; m0_adr = 15'h7FFF;
    m1_cyc = 1; m1_stb = 1; m1_adr = 15'h0000;
    tick();
    for (int i = 0; i < 3; i++) begin
      m1_stb = 1; m1_adr = 15'(15'h0040 + i);
      exp_q.push_back(16'(16'hA000 + i));
      s_ack = 1; s_rdat = 16'(16'hA000 + i);
      mid();
      n_cmp++; if (gnt !== 2'b10 || m1_ack !== 1'b1 || m0_ack !== 1'b0 || s_adr !== 15'(15'h0040 + i)) begin
        n_bad++; $display("FAIL lock_strobe%0d: gnt=%b m1_ack=%b m0_ack=%b adr=%h", i, gnt, m1_ack, m0_ack, s_adr);
      end
      if (m1_ack === 1'b1) begin
        done++;
        exp_v = (exp_q.size() > 0) ? exp_q.pop_front() : 16'hxxxx;
        n_cmp++; if (m1_rdat !== exp_v) begin
          n_bad++; $display("FAIL lock_data%0d: got %h, want %h", i, m1_rdat, exp_v);
        end
      end
      tick();
      s_ack = 0; m1_stb = 0;
      mid();
      n_cmp++; if (s_stb !== 1'b0 || gnt !== 2'b10) begin
        n_bad++; $display("FAIL stb_gap%0d: s_stb=%b gnt=%b, want 0/10", i, s_stb, gnt);
      end
      tick();
    end
    m1_cyc = 0;
    tick();
    mid();
    n_cmp++; if (gnt !== 2'b01 || done != 3) begin
      n_bad++; $display("FAIL lock_release: gnt=%b done=%0d, want 01/3", gnt, done);
    end
    tick();
    idle_all();
    tick();
  endtask

  task automatic test_timeout(input bit ack_last);
    bit seen_err;
    seen_err = 0;
    m0_cyc = 1; m0_stb = 1; m0_adr = 15'h0222;
    tick();
    for (int k = 1; k <= 16; k++) begin
      if (k == 16 && ack_last) begin
        s_ack = 1; s_rdat = 16'h1234;
      end
      mid();
      if (k < 16 || ack_last) begin
        n_cmp++; if (m0_err !== 1'b0) begin
          n_bad++; $display("FAIL early_err: cycle %0d m0_err=%b, want 0", k, m0_err);
        end
      end else begin
        n_cmp++; if (m0_err !== 1'b1 || m1_err !== 1'b0) begin
          n_bad++; $display("FAIL timeout_err: m0_err=%b m1_err=%b, want 1/0", m0_err, m1_err);
        end
        seen_err = 1;
      end
      if (k == 16 && ack_last) begin
        n_cmp++; if (m0_ack !== 1'b1) begin
          n_bad++; $display("FAIL ack_beats_timeout: m0_ack=%b, want 1", m0_ack);
        end
      end
      tick();
    end
    s_ack = 0;
    mid();
    if (ack_last) begin
      n_cmp++; if (gnt !== 2'b01 || m0_err !== 1'b0) begin
        n_bad++; $display("FAIL grant_kept: gnt=%b err=%b, want 01/0", gnt, m0_err);
      end
    end else begin
      n_cmp++; if (gnt !== 2'b00 || !seen_err) begin
        n_bad++; $display("FAIL forced_release: gnt=%b, want 00", gnt);
      end
      // Late ack while idle must not reach any master.
      m0_cyc = 0; m0_stb = 0;
      s_ack = 1; s_rdat = 16'hDEAD;
      #1;
      n_cmp++; if (m0_ack !== 1'b0 || m1_ack !== 1'b0 || m0_rdat !== 16'h0000) begin
        n_bad++; $display("FAIL late_ack: m0_ack=%b m1_ack=%b m0_dat=%h, want 0/0/0000", m0_ack, m1_ack, m0_rdat);
      end
    end
    tick();
    idle_all();
    tick();
    tick();
  endtask

  initial begin
    test_reset();
    test_single();
    test_tie();
    test_lock();
    test_timeout(1'b0);
    test_timeout(1'b1);
    n_cmp++; if (exp_q.size() != 0) begin
      n_bad++; $display("FAIL scoreboard_drain: %0d left, want 0", exp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL watchdog_timeout: simulation time limit reached");
    $fatal(1, "time limit");
  end

endmodule
`default_nettype wire
